// File: rtl/prog_sequencer.sv
// Program sequencer: IDLE/RUN/DONE controller that steps a program counter,
// evaluates conditional absolute/relative branches and stops on halt or cycle limit.
module prog_sequencer #(
  parameter int unsigned    D         = 12,
  parameter int unsigned    IW        = 9,
  parameter logic [D-1:0]   START     = '0,
  parameter logic [IW-1:0]  HALT_CODE = '1,
  parameter int unsigned    CW        = 16,
  parameter int unsigned    TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [IW-1:0] mach_code,
  input  logic          stall,
  input  logic          abs_branch,
  input  logic          rel_branch,
  input  logic [D-1:0]  target,
  input  logic [1:0]    flag_sel,
  input  logic          br_invert,
  input  logic          zero,
  input  logic          ngtv,
  input  logic          scry,
  output logic [D-1:0]  prog_ctr,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          flag_s;
  logic          cond_s;
  logic          halt_s;

  always_comb begin
    flag_s = 1'b1;
    case (flag_sel)
      2'b00:   flag_s = 1'b1;
      2'b01:   flag_s = zero;
      2'b10:   flag_s = ngtv;
      2'b11:   flag_s = scry;
      default: flag_s = 1'b1;
    endcase
    cond_s = flag_s ^ br_invert;
    halt_s = !stall && (mach_code == HALT_CODE);
  end

  // Halt beats the cycle limit; a limit-terminated cycle keeps PC and count unchanged.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        pc_d = START;
        if (req) begin
          state_d = S_RUN;
          cnt_d   = '0;
          to_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (halt_s) begin
          state_d = S_DONE;
          cnt_d   = cnt_q + CW'(1);
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (stall) begin
            pc_d = pc_q;
          end else if (cond_s && abs_branch) begin
            pc_d = target;
          end else if (cond_s && rel_branch) begin
            pc_d = pc_q + target;
          end else begin
            pc_d = pc_q + D'(1);
          end
        end
      end
      S_DONE: begin
        if (!req) begin
          state_d = S_IDLE;
          pc_d    = START;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = START;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= START;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign prog_ctr  = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = to_q;
  assign cycle_cnt = cnt_q;

endmodule
